// File: rtl/qsub_serial_if.sv
// qsub_serial handshake bundle: start/operands in, busy/done/result out.
// master drives operands, slave is the serial subtractor.
interface qsub_serial_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] c;
  logic            ovf;

  modport master (
    output start, a, b,
    input  busy, done, c, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, c, ovf
  );
endinterface

// File: rtl/qsub_serial.sv
// Bit-serial sign-magnitude subtractor c = a - b, one magnitude bit per clock.
// Optional QSUB_SAT_EN: saturate magnitude to all ones on add-path overflow.
module qsub_serial #(
  parameter int SIZE = 8
) (
  input  logic          clk,
  input  logic          rst,
  qsub_serial_if.slave  bus
);

  localparam int MW = SIZE - 1;
  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   x_q, x_d;
  logic [MW-1:0]   y_q, y_d;
  logic            add_q, add_d;
  logic            sgn_q, sgn_d;
  logic            cb_q, cb_d;
  logic [SIZE-1:0] c_q, c_d;
  logic            ovf_q, ovf_d;

  logic            busy_o;
  logic            done_o;

  logic [MW-1:0]   a_mag, b_mag;
  logic            a_sgn, b_eff;
  logic            is_add, a_ge;
  logic            accept;
  logic            last;
  logic            xb, yb, sum, cout;
  logic [MW-1:0]   mag_fin;
  logic            ovf_fin;
  logic            sgn_fin;

  // Operand classification done once, combinationally, at acceptance
  always_comb begin
    a_mag  = bus.a[MW-1:0];
    b_mag  = bus.b[MW-1:0];
    a_sgn  = bus.a[SIZE-1];
    b_eff  = ~bus.b[SIZE-1];
    is_add = (a_sgn == b_eff);
    a_ge   = (a_mag >= b_mag);
    accept = (state_q == IDLE) && bus.start;
  end

  // One-bit full adder / full subtractor on the current bit position
  always_comb begin
    xb   = x_q[cnt_q];
    yb   = y_q[cnt_q];
    sum  = xb ^ yb ^ cb_q;
    cout = add_q ? ((xb & yb) | (cb_q & (xb ^ yb)))
                 : ((~xb & yb) | (~(xb ^ yb) & cb_q));
    last = (cnt_q == CW'(SIZE - 2));
  end

  // Final magnitude, overflow handling and zero-sign normalization
  always_comb begin
    mag_fin         = c_q[MW-1:0];
    mag_fin[MW-1]   = sum;
    ovf_fin         = add_q & cout;
`ifdef QSUB_SAT_EN
    if (ovf_fin) begin
      mag_fin = '1;
    end
`endif
    sgn_fin = (mag_fin != '0) ? sgn_q : 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      CALC: busy_o = 1'b1;
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch at accept, one bit per CALC edge
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    add_d = add_q;
    sgn_d = sgn_q;
    cb_d  = cb_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    if (accept) begin
      cnt_d = '0;
      add_d = is_add;
      if (is_add || a_ge) begin
        x_d   = a_mag;
        y_d   = b_mag;
        sgn_d = a_sgn;
      end else begin
        x_d   = b_mag;
        y_d   = a_mag;
        sgn_d = b_eff;
      end
      cb_d  = 1'b0;
      c_d   = '0;
      ovf_d = 1'b0;
    end else if (state_q == CALC) begin
      cb_d = cout;
      if (last) begin
        cnt_d = '0;
        c_d   = {sgn_fin, mag_fin};
        ovf_d = ovf_fin;
      end else begin
        cnt_d      = cnt_q + 1'b1;
        c_d[cnt_q] = sum;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      add_q <= 1'b0;
      sgn_q <= 1'b0;
      cb_q  <= 1'b0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      add_q <= add_d;
      sgn_q <= sgn_d;
      cb_q  <= cb_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.c    = c_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_qsub_serial.sv
// Scoreboard bench for qsub_serial (SIZE=8), directed vectors.
// Expectations follow QSUB_SAT_EN when it is defined.
module tb_qsub_serial;
  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qsub_serial_if #(.SIZE(SIZE)) bus();

  qsub_serial #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total    = 0;
  int         bad      = 0;
  int         done_cnt = 0;
  logic       prev_done = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Monitor: pop expected result whenever done is presented
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        done_cnt++;
        chk("done_width", 32'(prev_done), 0);
        chk("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("c", 32'(bus.c), 32'(mon_e[7:0]));
          chk("ovf", 32'(bus.ovf), 32'(mon_e[8]));
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_done();
    int n = 0;
    int k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) n++;
      k++;
    end
    chk("done_timeout", 32'(k < 20), 1);
    chk("busy_cycles", n, SIZE - 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ec, input logic eo);
    exp_q.push_back({eo, ec});
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    wait_done();
    @(posedge clk);
    #1;
    chk("c_hold", 32'(bus.c), 32'(ec));
    chk("idle_busy", 32'(bus.busy), 0);
  endtask

  int d0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_c", 32'(bus.c), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0);
    run_op(8'h03, 8'h05, 8'h82, 1'b0);
    run_op(8'h94, 8'hB2, 8'h1E, 1'b0);
`ifdef QSUB_SAT_EN
    run_op(8'hE4, 8'h32, 8'hFF, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h7F, 1'b1);
    run_op(8'hC0, 8'h40, 8'hFF, 1'b1);
`else
    run_op(8'hE4, 8'h32, 8'h96, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h7E, 1'b1);
    run_op(8'hC0, 8'h40, 8'h00, 1'b1);
`endif
    run_op(8'h07, 8'h07, 8'h00, 1'b0);
    run_op(8'h80, 8'h00, 8'h00, 1'b0);
    run_op(8'h85, 8'h80, 8'h85, 1'b0);
    run_op(8'h00, 8'h85, 8'h05, 1'b0);
    run_op(8'h2A, 8'h15, 8'h15, 1'b0);
    run_op(8'h81, 8'h01, 8'h82, 1'b0);

    // start held with new operands through CALC and DONE
    d0 = done_cnt;
    exp_q.push_back({1'b0, 8'h0A});
    bus.a = 8'h0C;
    bus.b = 8'h02;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.a = 8'h11;
    bus.b = 8'h22;
    repeat (SIZE) @(posedge clk);
    #1 bus.start = 1'b0;
    chk("hs_busy", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hs_one_done", done_cnt - d0, 1);
    chk("hs_c_hold", 32'(bus.c), 32'h0A);

    // reset in the middle of CALC
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_c", 32'(bus.c), 0);
    chk("mrst_ovf", 32'(bus.ovf), 0);
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    chk("mrst_no_done", done_cnt - d0, 0);
    run_op(8'h09, 8'h04, 8'h05, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
